// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The FETCH_ALIGN_CHECK_EN build option is consumed in inst_fetch_unit.sv.
package inst_fetch_unit_pkg;

  localparam int DATAWIDTH      = 32;
  localparam int INST_MEM_SIZE  = 1024;
  localparam int INST_BYTES     = 4;
  localparam logic [DATAWIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [DATAWIDTH-1:0] pc;
    logic [31:0]          inst;
  } fq_entry_t;

  function automatic logic [DATAWIDTH-1:0] word_align(input logic [DATAWIDTH-1:0] addr);
    return {addr[DATAWIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory port, redirect request and
// decode handshake. master = fetch unit, slave = memory/decode/branch side.
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic [DATAWIDTH-1:0] inst_addr;
  logic [31:0]          inst_rdata;
  logic                 redirect_valid;
  logic [DATAWIDTH-1:0] redirect_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic [DATAWIDTH-1:0] out_pc;

  modport master (
    output inst_addr,
    input  inst_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  inst_addr,
    output inst_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries with simultaneous push/pop and flush.
// Storage is not reset; the head is qualified by the caller using o_empty.
module inst_fetch_unit_fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  fq_entry_t                    i_wdata,
  output fq_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fq_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Push into a full queue is legal when a pop happens in the same cycle:
  // the read sees the old slot contents before the write lands.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a zero-latency memory and
// queues {pc, inst} for decode. Build option: FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                   FQ_DEPTH = 2,
  parameter logic [DATAWIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  inst_fetch_unit_if.master  bus,
  output logic               misalign_err
);

  localparam int CW = $clog2(FQ_DEPTH+1);

  logic [DATAWIDTH-1:0] r_pc;
  logic [DATAWIDTH-1:0] w_redirect_target;
  logic                 w_halt;
  logic                 w_enq;
  logic                 w_deq;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  fq_entry_t            w_head;
  fq_entry_t            w_wdata;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_halt;
  logic r_misalign;

  // A misaligned target parks fetch until software redirects somewhere sane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      if (bus.redirect_pc[1:0] != 2'b00) begin
        r_halt     <= 1'b1;
        r_misalign <= 1'b1;
      end else begin
        r_halt     <= 1'b0;
      end
    end
  end

  assign w_halt            = r_halt;
  assign misalign_err      = r_misalign;
  assign w_redirect_target = bus.redirect_pc;
`else
  assign w_halt            = 1'b0;
  assign misalign_err      = 1'b0;
  assign w_redirect_target = word_align(bus.redirect_pc);
`endif

  assign w_deq   = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
  assign w_enq   = fetch_en & ~bus.redirect_valid & ~w_halt & (~w_full | w_deq);
  assign w_wdata = '{pc: r_pc, inst: bus.inst_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= w_redirect_target;
    else if (w_enq)              r_pc <= r_pc + DATAWIDTH'(INST_BYTES);
  end

  inst_fetch_unit_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.inst_addr = r_pc;
  assign bus.out_valid = (w_count != '0);
  assign bus.out_inst  = w_empty ? 32'h0 : w_head.inst;
  assign bus.out_pc    = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed steps plus random traffic against a
// queue-based reference model of the fetch/redirect rules.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic fetch_en;
  logic misalign_err;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .bus          (bus),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  assign bus.inst_rdata = 32'hA000_0000 | bus.inst_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit vld;
    vld = (mq.size() != 0);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, vld});
    chk("out_pc",    bus.out_pc,   vld ? mq[0].pc   : 32'h0);
    chk("out_inst",  bus.out_inst, vld ? mq[0].inst : 32'h0);
    chk("inst_addr", bus.inst_addr, m_pc);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  task automatic step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit deq;
    bit enq;
    @(negedge clk);
    fetch_en           = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
    check_all();
    deq = (mq.size() != 0) && rdy && !rv;
    enq = fe && !rv && !m_halt && ((mq.size() < DEPTH) || deq);
    @(posedge clk);
    if (rv) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = rpc;
      if (rpc % 4 != 0) begin
        m_mis  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_halt = 1'b0;
      end
`else
      m_pc = rpc - (rpc % 4);
`endif
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        mq.push_back('{pc: m_pc, inst: 32'hA000_0000 | m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Asserts reset between clock edges and checks that it takes effect at once.
  task automatic do_reset();
    #2;
    rst                = 1'b1;
    fetch_en           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_inst_addr", bus.inst_addr, RPC);
    chk("rst_out_pc",    bus.out_pc, 32'h0);
    chk("rst_misalign",  {31'b0, misalign_err}, 32'h0);
    mq.delete();
    m_pc   = RPC;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    fetch_en           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    do_reset();

    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'h42, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h80, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           32'($urandom_range(0, 1023)),
           $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the PC and drives a byte address to the combinational, little-endian, word-wide instruction memory. Captures the returned 32-bit word, then buffers {pc, inst} pairs in a small fetch queue.
- Presents the queue head to decode with a valid/ready handshake. Redirects from branch/jump resolution flush the queue and reload the PC.

Parameters:
- FQ_DEPTH, 2, fetch-queue entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  permits new fetches; deasserted = PC holds, queue still drains.
- inst_addr  out  `datawidth  byte address to instruction memory (= pc_q).
- inst_rdata  in  32  instruction word returned combinationally for inst_addr.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  `datawidth  redirect target byte address.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  `datawidth  head PC.
- misalign_err  out  1  sticky misaligned-redirect flag (tied 0 when the optional feature is compiled out).

Behaviour:
- Reset: pc_q=RESET_PC; queue count/read/write pointers = 0; out_valid=0; out_inst=0; out_pc=0; misalign_err=0. Reset is asynchronous and may assert mid-stream; all state clears immediately.
- inst_addr = pc_q, purely combinational. Memory latency is 0, so inst_rdata is sampled in the same cycle.
- enq = fetch_en & ~redirect_valid & (count<FQ_DEPTH | deq).
  - Full queue with a simultaneous dequeue still enqueues, giving sustained throughput of one instruction per cycle.
- deq = out_valid & out_ready & ~redirect_valid.
- On enq: write {pc_q, inst_rdata} at wr_ptr; wr_ptr++ (mod FQ_DEPTH); pc_q <= pc_q + 4, wrapping modulo 2^`datawidth.
- On deq: rd_ptr++ (mod FQ_DEPTH).
- count: +1 on enq only, −1 on deq only, unchanged on both or neither.
- out_valid = (count!=0). out_inst/out_pc are driven from the rd_ptr entry and are zero when empty.
  - An enqueued word is visible on out_* the cycle after enq. Fetch-to-decode latency is 1 cycle.
- Redirect (highest priority):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, pc_q=redirect_pc.
  - No enq and no deq in the redirect cycle; out_ready is ignored.
  - out_valid=0 in the cycle after the redirect. The first word from the target appears on the second cycle after the redirect if fetch_en=1.
- Back-to-back redirects: the last one wins; each cycle reloads pc_q.
- fetch_en=0 with out_ready=1: the queue drains to empty and pc_q holds.
- out_* are stable while out_valid & ~out_ready & ~redirect_valid.
- No bounds check against InstMemorySize; the address is passed through.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err (sticky until rst) and sets a halt flag that blocks enq.
  - pc_q is still loaded with the raw redirect_pc.
  - A later aligned redirect clears halt (not misalign_err).
- Undefined:
  - redirect_pc[1:0] is forced to 0 when loading pc_q.
  - misalign_err is tied 0 and no halt flag exists.

Decomposition:
- Shared package/include riscv_ctrl_para.v holds `datawidth and `InstMemorySize, plus the new constants `INST_BYTES (4) and `RESET_PC_DEFAULT.
- One sub-module: fetch_queue, a parameterised sync FIFO of {pc, inst} entries with simultaneous push/pop, a flush input, and count/full/empty outputs.
- inst_fetch_unit holds the PC, redirect logic and alignment check.

Test Plan:
- Bench memory model returns inst_rdata = 32'hA000_0000 | inst_addr.
- Reset then fetch_en=1, out_ready=1 -> out_valid rises one cycle after reset release; out_pc 0,4,8,12 on consecutive cycles with out_inst A000_0000, A000_0004, …
- out_ready=0 for 5 cycles -> queue fills at FQ_DEPTH=2 and holds (pc 0 and 4); inst_addr holds at 8; out_pc stays 0. On out_ready=1, sequence resumes 0,4,8 without loss or duplication.
- Redirect to 0x40 while queue full and out_ready=1 -> next cycle out_valid=0, inst_addr=0x40; the following cycle out_pc=0x40, out_inst=A000_0040; no stale pc 4/8 is seen.
- fetch_en=0 with 2 queued entries and out_ready=1 -> two entries drain, then out_valid=0; inst_addr is frozen throughout.
- Redirect to 0x42 -> with FETCH_ALIGN_CHECK_EN: misalign_err=1, no out_valid until a redirect to 0x80, then out_pc=0x80. Without the macro: out_pc=0x40.
- rst asserted mid-stream (async, between clock edges) -> out_valid=0 and inst_addr=RESET_PC immediately; after release, fetch restarts at RESET_PC.
